aftab_dawu_store_sequencer: RTL

Sequential store-side data adjustment unit for the AFTAB datapath, parametrised in bus width. It accepts one store request, performs the misalignment check, and either traps the store or splits it into one or two aligned bus writes with lane-shifted data and byte enables. It drives the data-memory write handshake and returns a single-cycle completion pulse to the controller.

---
 rtl/aftab_dawu_store_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/aftab_dawu_store_sequencer.sv
// AFTAB store-side data adjustment: traps or splits one store into aligned,
// lane-shifted bus writes with byte enables and a write handshake.
module aftab_dawu_store_sequencer #(
    parameter int size = 32,
    localparam int LANES = size / 8,
    localparam int OFFW = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startDAWU,
    input  logic [1:0]       nBytes,
    input  logic [size-1:0]  addrIn,
    input  logic [size-1:0]  dataIn,
    input  logic             checkMisalignedDAWU,
    input  logic             memReady,
    output logic [size-1:0]  addrOut,
    output logic [size-1:0]  dataOut,
    output logic [LANES-1:0] bytesEn,
    output logic             writeMem,
    output logic             storeMisalignedFlag,
    output logic             completeDAWU,
    output logic             busyDAWU
);

    localparam int NW = OFFW + 2;
    localparam int WW = size - OFFW;

    typedef enum logic [2:0] {
        IDLE,
        WR1,
        WR2,
        DONE,
        ERR
    } state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    word_q, word_d;
    logic [size-1:0]  data_q, data_d;
    logic [OFFW-1:0]  off_q, off_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic             cross_q, cross_d;

    logic [OFFW-1:0]  req_off;
    logic [NW-1:0]    req_n;
    logic [LANES-1:0] req_mask;
    logic             req_illegal;
    logic             req_misaligned;
    logic             req_cross;

    logic [OFFW:0]    rem;
    logic [WW-1:0]    word_next;

    // Decode the incoming request; only consulted when a start is accepted in IDLE.
    always_comb begin
        req_off     = addrIn[OFFW-1:0];
        req_illegal = 1'b0;
        case (nBytes)
            2'b00: begin
                req_n    = NW'(1);
                req_mask = LANES'(1);
            end
            2'b01: begin
                req_n    = NW'(2);
                req_mask = LANES'(3);
            end
            2'b11: begin
                req_n    = NW'(4);
                req_mask = LANES'(15);
            end
            default: begin
                req_n       = NW'(8);
                req_mask    = LANES'(255);
                req_illegal = (LANES < 8);
            end
        endcase
        req_misaligned = (({2'b00, req_off} & (req_n - NW'(1))) != '0);
        req_cross      = (({2'b00, req_off} + req_n) > NW'(LANES));
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        data_d  = data_q;
        off_d   = off_q;
        mask_d  = mask_q;
        cross_d = cross_q;
        case (state_q)
            IDLE: begin
                if (startDAWU) begin
                    word_d  = addrIn[size-1:OFFW];
                    data_d  = dataIn;
                    off_d   = req_off;
                    mask_d  = req_mask;
                    cross_d = req_cross;
                    if (req_illegal || (req_misaligned && checkMisalignedDAWU)) begin
                        state_d = ERR;
                    end else begin
                        state_d = WR1;
                    end
                end
            end
            WR1: begin
                if (memReady) begin
                    state_d = cross_q ? WR2 : DONE;
                end
            end
            WR2: begin
                if (memReady) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Second beat carries the bytes that spilled past the top lane of the first word.
    always_comb begin
        rem                 = (OFFW + 1)'(LANES) - {1'b0, off_q};
        word_next           = word_q + WW'(1);
        addrOut             = '0;
        dataOut             = '0;
        bytesEn             = '0;
        writeMem            = 1'b0;
        storeMisalignedFlag = 1'b0;
        completeDAWU        = 1'b0;
        busyDAWU            = (state_q != IDLE);
        case (state_q)
            WR1: begin
                writeMem = 1'b1;
                addrOut  = {word_q, {OFFW{1'b0}}};
                dataOut  = data_q << {off_q, 3'b000};
                bytesEn  = mask_q << off_q;
            end
            WR2: begin
                writeMem = 1'b1;
                addrOut  = {word_next, {OFFW{1'b0}}};
                dataOut  = data_q >> {rem, 3'b000};
                bytesEn  = mask_q >> rem;
            end
            DONE: begin
                completeDAWU = 1'b1;
            end
            ERR: begin
                completeDAWU        = 1'b1;
                storeMisalignedFlag = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            data_q  <= '0;
            off_q   <= '0;
            mask_q  <= '0;
            cross_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            data_q  <= data_d;
            off_q   <= off_d;
            mask_q  <= mask_d;
            cross_q <= cross_d;
        end
    end

endmodule
